apu_length_bank: RTL and testbench

Parametrised bank of APU length counters for the PAPU audio path. It sits between the tone generators (square, triangle, noise) and the mixer. Each channel holds a length counter loaded from the standard 32-entry NES length table on an explicit write strobe and decremented on half-frame ticks. The counter mutes that channel's sample when it reaches zero. Half-frame ticks come from an internal divider or from an external frame sequencer, and per-channel status is exported for the $4015 readback.

---
 rtl/apu_length_bank.sv | 130 +++++++++++++
 tb/tb_apu_length_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apu_length_bank.sv
// apu_length_bank
// Bank of NES-style length counters sitting between the tone generators and
// the mixer. Each channel is loaded from the 32-entry length table, counts
// down on half-frame ticks and mutes its sample once it reaches zero.

module apu_length_bank #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_W   = 4,
    parameter int DIV_PERIOD = 29830,
    parameter int TICK_SRC   = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DIV_W     = (DIV_PERIOD > 2) ? $clog2(DIV_PERIOD) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [CH_W-1:0]              wr_ch,
    input  logic [4:0]                   wr_len,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            halt,
    input  logic                         ext_tick,
    input  logic [NUM_CH*SAMPLE_W-1:0]   snd_in,
    output logic [NUM_CH*SAMPLE_W-1:0]   snd_out,
    output logic [NUM_CH-1:0]            active,
    output logic                         tick_out
);

    logic [DIV_W-1:0]            div_cnt_q, div_cnt_d;
    logic                        int_tick;
    logic                        tick;
    logic                        tick_out_q, tick_out_d;
    logic [7:0]                  cnt_q [NUM_CH];
    logic [7:0]                  cnt_d [NUM_CH];
    logic [NUM_CH*SAMPLE_W-1:0]  snd_out_q, snd_out_d;
    int                          wr_sel;

    // Standard NES length table, indexed by the 5-bit value written by the CPU
    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;
            5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;
            5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;
            5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;
            5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;
            5'd9:  val = 8'd8;
            5'd10: val = 8'd60;
            5'd11: val = 8'd10;
            5'd12: val = 8'd14;
            5'd13: val = 8'd12;
            5'd14: val = 8'd26;
            5'd15: val = 8'd14;
            5'd16: val = 8'd12;
            5'd17: val = 8'd16;
            5'd18: val = 8'd24;
            5'd19: val = 8'd18;
            5'd20: val = 8'd48;
            5'd21: val = 8'd20;
            5'd22: val = 8'd96;
            5'd23: val = 8'd22;
            5'd24: val = 8'd192;
            5'd25: val = 8'd24;
            5'd26: val = 8'd72;
            5'd27: val = 8'd26;
            5'd28: val = 8'd16;
            5'd29: val = 8'd28;
            5'd30: val = 8'd32;
            default: val = 8'd30;
        endcase
        return val;
    endfunction

    // Free-running half-frame divider and selection of the tick source in use;
    // the divider keeps running even when the external tick is selected
    always_comb begin
        int_tick   = (div_cnt_q == DIV_W'(DIV_PERIOD - 1));
        div_cnt_d  = int_tick ? '0 : div_cnt_q + 1'b1;
        tick       = (TICK_SRC == 0) ? int_tick : ext_tick;
        tick_out_d = tick;
    end

    // Per-channel counter update (disable > load > decrement > hold) and
    // sample gating based on the counter value before this cycle's update
    always_comb begin
        wr_sel    = int'(wr_ch);
        snd_out_d = '0;
        active    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!ch_enable[i]) begin
                cnt_d[i] = 8'd0;
            end else if (wr_en && (wr_sel == i)) begin
                cnt_d[i] = len_lookup(wr_len);
            end else if (tick && !halt[i] && (cnt_q[i] != 8'd0)) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
            active[i] = (cnt_q[i] != 8'd0);
            if (cnt_q[i] != 8'd0) begin
                snd_out_d[i*SAMPLE_W +: SAMPLE_W] = snd_in[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            tick_out_q <= 1'b0;
            snd_out_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            div_cnt_q  <= div_cnt_d;
            tick_out_q <= tick_out_d;
            snd_out_q  <= snd_out_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign snd_out  = snd_out_q;
    assign tick_out = tick_out_q;

endmodule

// File: tb/tb_apu_length_bank.sv
// tb_apu_length_bank
// Drives one internally-ticked bank and one externally-ticked bank from the
// same stimulus. Five channels are used so that a 3-bit wr_ch can address a
// channel number that does not exist.

module tb_apu_length_bank;

    localparam int NCH  = 5;
    localparam int SW   = 4;
    localparam int DIVP = 4;
    localparam int LEN_TAB [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                                    12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    typedef struct packed {
        logic [NCH-1:0]    act;
        logic [NCH*SW-1:0] snd;
        logic              tk;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [2:0]        wr_ch;
    logic [4:0]        wr_len;
    logic [NCH-1:0]    ch_enable;
    logic [NCH-1:0]    halt;
    logic              ext_tick;
    logic [NCH*SW-1:0] snd_in;
    logic [NCH*SW-1:0] snd_out_i, snd_out_e;
    logic [NCH-1:0]    active_i, active_e;
    logic              tick_out_i, tick_out_e;

    int   checks = 0;
    int   errors = 0;
    int   m_cnt [2][NCH];
    int   m_div [2];
    exp_t q_int [$];
    exp_t q_ext [$];

    always #5 clk = ~clk;

    apu_length_bank #(.NUM_CH(NCH), .SAMPLE_W(SW), .DIV_PERIOD(DIVP), .TICK_SRC(0)) dut_int (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_len(wr_len),
        .ch_enable(ch_enable), .halt(halt), .ext_tick(ext_tick), .snd_in(snd_in),
        .snd_out(snd_out_i), .active(active_i), .tick_out(tick_out_i)
    );

    apu_length_bank #(.NUM_CH(NCH), .SAMPLE_W(SW), .DIV_PERIOD(DIVP), .TICK_SRC(1)) dut_ext (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_len(wr_len),
        .ch_enable(ch_enable), .halt(halt), .ext_tick(ext_tick), .snd_in(snd_in),
        .snd_out(snd_out_e), .active(active_e), .tick_out(tick_out_e)
    );

    // Compare one observed value against its expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one bank for the edge about to happen
    task automatic modelStep(input int d, output exp_t e);
        logic tk;
        e = '0;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) m_cnt[d][c] = 0;
            m_div[d] = 0;
        end else begin
            tk   = (d == 1) ? ext_tick : (m_div[d] == DIVP - 1);
            e.tk = tk;
            for (int c = 0; c < NCH; c++) begin
                if (m_cnt[d][c] != 0) e.snd[c*SW +: SW] = snd_in[c*SW +: SW];
                if (!ch_enable[c])                              m_cnt[d][c] = 0;
                else if (wr_en && int'(wr_ch) == c)             m_cnt[d][c] = LEN_TAB[wr_len];
                else if (tk && !halt[c] && m_cnt[d][c] > 0)     m_cnt[d][c] = m_cnt[d][c] - 1;
                e.act[c] = (m_cnt[d][c] != 0);
            end
            m_div[d] = (m_div[d] == DIVP - 1) ? 0 : m_div[d] + 1;
        end
    endtask

    // Push expectations for the current inputs, clock once, then compare
    task automatic applyStimulus();
        exp_t ei, ee, oi, oe;
        modelStep(0, ei);
        modelStep(1, ee);
        q_int.push_back(ei);
        q_ext.push_back(ee);
        @(posedge clk);
        @(negedge clk);
        oi = q_int.pop_front();
        oe = q_ext.pop_front();
        checkOutput("int_active",   32'(active_i),   32'(oi.act));
        checkOutput("int_snd_out",  32'(snd_out_i),  32'(oi.snd));
        checkOutput("int_tick_out", 32'(tick_out_i), 32'(oi.tk));
        checkOutput("ext_active",   32'(active_e),   32'(oe.act));
        checkOutput("ext_snd_out",  32'(snd_out_e),  32'(oe.snd));
        checkOutput("ext_tick_out", 32'(tick_out_e), 32'(oe.tk));
    endtask

    // Idle cycles with random samples
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            snd_in = NCH*SW'($urandom);
            applyStimulus();
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_len = '0;
        ch_enable = '0; halt = '0; ext_tick = 1'b0; snd_in = 20'h5693A;

        // Reset and free-running divider with no loads
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus(); applyStimulus(); applyStimulus();
        checkOutput("tick_out_c3", 32'(tick_out_i), 32'd0);
        applyStimulus();
        checkOutput("tick_out_c4", 32'(tick_out_i), 32'd1);
        applyStimulus();
        checkOutput("tick_out_c5", 32'(tick_out_i), 32'd0);
        checkOutput("idle_active", 32'(active_i), 32'd0);
        checkOutput("idle_snd",    32'(snd_out_i), 32'd0);
        run(6);

        // Load ch0 with value 2 and watch it unmute, then expire
        ch_enable = 5'h1F; snd_in = 20'h5693A;
        wr_en = 1'b1; wr_ch = 3'd0; wr_len = 5'd3;
        applyStimulus();
        wr_en = 1'b0;
        checkOutput("ld0_active", 32'(active_i[0]), 32'd1);
        applyStimulus();
        checkOutput("ld0_snd", 32'(snd_out_i[3:0]), 32'hA);
        for (int k = 0; k < 8; k++) applyStimulus();
        checkOutput("ld0_expired", 32'(active_i[0]), 32'd0);
        applyStimulus();
        checkOutput("ld0_muted", 32'(snd_out_i[3:0]), 32'h0);

        // Halted ch1 holds 254 through 300 ticks, then runs out
        wr_en = 1'b1; wr_ch = 3'd1; wr_len = 5'd1; halt = 5'b00010;
        applyStimulus();
        wr_en = 1'b0;
        run(1200);
        checkOutput("halt_hold_int", 32'(active_i[1]), 32'd1);
        checkOutput("halt_hold_ext", 32'(active_e[1]), 32'd1);
        halt = '0;
        run(1020);
        checkOutput("halt_release", 32'(active_i[1]), 32'd0);

        // Load ch2 in the same cycle as an internal tick
        for (int g = 0; g < DIVP && m_div[0] != DIVP - 1; g++) run(1);
        wr_en = 1'b1; wr_ch = 3'd2; wr_len = 5'd3;
        applyStimulus();
        wr_en = 1'b0;
        run(4);
        checkOutput("ldtick_one_left", 32'(active_i[2]), 32'd1);
        run(4);
        checkOutput("ldtick_expired", 32'(active_i[2]), 32'd0);

        // Disable ch3, load while disabled, write to a nonexistent channel
        wr_en = 1'b1; wr_ch = 3'd3; wr_len = 5'd0;
        applyStimulus();
        wr_en = 1'b0;
        run(4);
        checkOutput("ch3_running", 32'(active_i[3]), 32'd1);
        ch_enable = 5'b10111;
        applyStimulus();
        checkOutput("ch3_disabled", 32'(active_i[3]), 32'd0);
        wr_en = 1'b1; wr_ch = 3'd3; wr_len = 5'd1;
        applyStimulus();
        checkOutput("ch3_load_disabled", 32'(active_i[3]), 32'd0);
        wr_ch = 3'd5;
        applyStimulus();
        wr_en = 1'b0;
        checkOutput("bad_ch_ch1", 32'(active_i[1]), 32'd0);
        checkOutput("bad_ch_ch4", 32'(active_i[4]), 32'd0);
        checkOutput("bad_ch_ch3", 32'(active_i[3]), 32'd0);
        ch_enable = 5'h1F;
        run(3);

        // External tick source: value 4 survives three pulses, not four
        wr_en = 1'b1; wr_ch = 3'd0; wr_len = 5'd5;
        applyStimulus();
        wr_en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            ext_tick = 1'b1; applyStimulus();
            ext_tick = 1'b0; run(5);
        end
        checkOutput("ext_three_ticks", 32'(active_e[0]), 32'd1);
        ext_tick = 1'b1; applyStimulus();
        ext_tick = 1'b0; applyStimulus();
        checkOutput("ext_four_ticks", 32'(active_e[0]), 32'd0);

        // Reset in the middle of a count
        wr_en = 1'b1; wr_ch = 3'd4; wr_len = 5'd8;
        applyStimulus();
        wr_en = 1'b0;
        run(2);
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("midrst_active_int", 32'(active_i), 32'd0);
        checkOutput("midrst_active_ext", 32'(active_e), 32'd0);
        rst_n = 1'b1;
        run(3);
        checkOutput("midrst_tick_c3", 32'(tick_out_i), 32'd0);
        run(1);
        checkOutput("midrst_tick_c4", 32'(tick_out_i), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
